// File: rtl/mipi_pkg.sv
// Shared MIPI HS/LP constants and transmitter state encoding, common to
// the serializer and the receiver.
package mipi_pkg;

  localparam logic [7:0] MIPI_SYNC_BYTE    = 8'hB8;
  localparam logic [7:0] MIPI_HS_ZERO_BYTE = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StLprq,
    StLpbr,
    StHsZero,
    StSync,
    StData,
    StTrail,
    StExit
  } mipi_tx_state_e;

endpackage

// File: rtl/mipi_tx_lp_timer.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
module mipi_tx_lp_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mipi_phy_ser.sv
// MIPI D-PHY byte-level transmitter: LP-11/01/00 entry, HS-zero, sync, payload,
// trail and LP-11 exit. Optional hs_data inversion under MIPI_TX_POLARITY_EN.
module mipi_phy_ser
  import mipi_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       hs_data,
  output logic             hs_oe,
  output logic             lp_p,
  output logic             lp_n,
  output logic             busy,
  output logic             underflow,
`ifdef MIPI_TX_POLARITY_EN
  input  logic             md_polarity,
`endif
  input  logic [CNT_W-1:0] lp_period,
  input  logic [CNT_W-1:0] hs_zero,
  input  logic [CNT_W-1:0] hs_trail
);

  mipi_tx_state_e state_q, state_d;
  logic [7:0]     data_q, data_d;
  logic           last_q, last_d;
  logic           uf_q, uf_d;
  logic           tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic           tmr_done;
  logic [7:0]     hs_raw;

  logic [CNT_W-1:0] lp_eff, hz_eff, ht_eff;

  // A programmed period of 0 behaves as 1.
  assign lp_eff = (lp_period == '0) ? CNT_W'(1) : lp_period;
  assign hz_eff = (hs_zero   == '0) ? CNT_W'(1) : hs_zero;
  assign ht_eff = (hs_trail  == '0) ? CNT_W'(1) : hs_trail;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    uf_d    = 1'b0;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StLprq;
      StLprq:   if (tmr_done) state_d = StLpbr;
      StLpbr:   if (tmr_done) state_d = StHsZero;
      StHsZero: begin
        if (tmr_done) begin
          state_d = StSync;
          // Seeds the trail polarity if the burst underflows before any byte.
          data_d  = MIPI_SYNC_BYTE;
          last_d  = 1'b0;
        end
      end
      StSync: begin
        if (in_valid) begin
          state_d = StData;
          data_d  = in_data;
          last_d  = in_last;
        end else begin
          state_d = StTrail;
          uf_d    = 1'b1;
        end
      end
      StData: begin
        if (last_q) begin
          state_d = StTrail;
        end else if (in_valid) begin
          data_d = in_data;
          last_d = in_last;
        end else begin
          state_d = StTrail;
          uf_d    = 1'b1;
        end
      end
      StTrail:  if (tmr_done) state_d = StExit;
      StExit:   if (tmr_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Reload the shared timer on every state change; the loaded value is
  // (cycles in the new state) - 1 since the state exits once the count hits 0.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      StLprq, StLpbr: tmr_val = lp_eff;
      StHsZero:       tmr_val = hz_eff - CNT_W'(1);
      StTrail:        tmr_val = ht_eff - CNT_W'(1);
      StExit:         tmr_val = lp_eff - CNT_W'(1);
      default:        tmr_val = '0;
    endcase
  end

  mipi_tx_lp_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .resetb     (resetb),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      uf_q    <= uf_d;
    end
  end

  always_comb begin
    hs_raw = 8'h00;
    hs_oe  = 1'b0;
    lp_p   = 1'b1;
    lp_n   = 1'b1;
    unique case (state_q)
      StLprq: lp_p = 1'b0;
      StLpbr: begin
        lp_p = 1'b0;
        lp_n = 1'b0;
      end
      StHsZero: begin
        hs_oe  = 1'b1;
        hs_raw = MIPI_HS_ZERO_BYTE;
      end
      StSync: begin
        hs_oe  = 1'b1;
        hs_raw = MIPI_SYNC_BYTE;
      end
      StData: begin
        hs_oe  = 1'b1;
        hs_raw = data_q;
      end
      StTrail: begin
        hs_oe  = 1'b1;
        hs_raw = {8{~data_q[0]}};
      end
      default: ;
    endcase
  end

`ifdef MIPI_TX_POLARITY_EN
  assign hs_data = hs_raw ^ {8{md_polarity}};
`else
  assign hs_data = hs_raw;
`endif

  assign in_ready  = (state_q == StSync) || ((state_q == StData) && !last_q);
  assign busy      = (state_q != StIdle);
  assign underflow = uf_q;

endmodule

// File: tb/tb_mipi_phy_ser.sv
// Scoreboard bench for mipi_phy_ser: expected HS bytes and per-burst LP timing
// are queued as each burst is driven and compared as the DUT produces them.
module tb_mipi_phy_ser;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [7:0]    hs_data;
  logic          hs_oe, lp_p, lp_n, busy, underflow;
  logic [CW-1:0] lp_period = 8'd4;
  logic [CW-1:0] hs_zero = 8'd3;
  logic [CW-1:0] hs_trail = 8'd2;
  logic          pol = 1'b0;

  mipi_phy_ser #(
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .hs_data     (hs_data),
    .hs_oe       (hs_oe),
    .lp_p        (lp_p),
    .lp_n        (lp_n),
    .busy        (busy),
    .underflow   (underflow),
`ifdef MIPI_TX_POLARITY_EN
    .md_polarity (pol),
`endif
    .lp_period   (lp_period),
    .hs_zero     (hs_zero),
    .hs_trail    (hs_trail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int c01;
    int c00;
    int cex;
    int cuf;
  } burst_t;

  logic [7:0] exp_hs[$];
  burst_t     exp_burst[$];
  bit         mon_en = 1'b1;
  bit         busy_prev = 1'b0;
  int         c01 = 0, c00 = 0, cex = 0, cuf = 0;

  always @(negedge clk) begin
    if (!resetb) begin
      busy_prev = 1'b0;
      c01 = 0; c00 = 0; cex = 0; cuf = 0;
    end else begin
      if (mon_en) begin
        if (hs_oe) begin
          check_val("hs_lp11", {30'd0, lp_p, lp_n}, 32'd3);
          if (exp_hs.size() == 0) check_val("hs_extra", 32'd1, 32'd0);
          else check_val("hs_data", {24'd0, hs_data}, {24'd0, exp_hs.pop_front()});
        end else if (busy) begin
          if (!lp_p && lp_n) c01++;
          else if (!lp_p && !lp_n) c00++;
          else if (lp_p && lp_n) cex++;
        end
        if (underflow) cuf++;
        if (busy_prev && !busy) begin
          burst_t e;
          if (exp_burst.size() == 0) begin
            check_val("burst_extra", 32'd1, 32'd0);
          end else begin
            e = exp_burst.pop_front();
            check_val("lp01_cycles", c01, e.c01);
            check_val("lp00_cycles", c00, e.c00);
            check_val("exit_cycles", cex, e.cex);
            check_val("underflow_pulses", cuf, e.cuf);
            check_val("hs_drained", exp_hs.size(), 0);
          end
          c01 = 0; c00 = 0; cex = 0; cuf = 0;
        end
      end
      busy_prev = busy;
    end
  end

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // sent < n stops presenting data after 'sent' accepted bytes (underflow).
  task automatic run_burst(input logic [7:0] b[8], input int n, input int sent,
                           input int lp, input int hz, input int ht);
    logic [7:0] pm;
    logic [7:0] lastb;
    burst_t     e;
    int idx, acc;
    bit take, started, uf_seen, done;
    pm = {8{pol}};
    lp_period = CW'(lp);
    hs_zero   = CW'(hz);
    hs_trail  = CW'(ht);
    for (int i = 0; i < max1(hz); i++) exp_hs.push_back(8'h00 ^ pm);
    exp_hs.push_back(8'hB8 ^ pm);
    for (int i = 0; i < sent; i++) exp_hs.push_back(b[i] ^ pm);
    lastb = (sent > 0) ? b[sent-1] : 8'hB8;
    for (int i = 0; i < max1(ht); i++) exp_hs.push_back({8{~lastb[0]}} ^ pm);
    e.c01 = max1(lp) + 1;
    e.c00 = max1(lp) + 1;
    e.cex = max1(lp);
    e.cuf = (sent < n) ? 1 : 0;
    exp_burst.push_back(e);

    idx = 0; acc = 0; started = 0; uf_seen = 0; done = 0;
    in_valid = 1'b1;
    in_data  = b[0];
    in_last  = (n == 1);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      if (underflow) uf_seen = 1;
      @(posedge clk);
      #1;
      if (busy) started = 1;
      if (take) begin
        acc++;
        idx++;
      end
      if (started && !busy) begin
        done = 1;
        in_valid = 1'b0;
      end else if (!started) begin
        in_valid = 1'b1;
      end else if (idx < sent) begin
        in_valid = 1'b1;
        in_data  = b[idx];
        in_last  = (idx == n - 1);
      end else begin
        // After an underflow keep offering junk while HS is on; none may be taken.
        in_valid = uf_seen && hs_oe && (sent < n);
        in_data  = 8'hEE;
        in_last  = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check_val("burst_timeout", 32'd0, 32'd1);
    check_val("bytes_accepted", acc, sent);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] bb[8];
    bit hit;
`ifdef MIPI_TX_POLARITY_EN
    pol = 1'b1;
`endif
    #2;
    check_val("rst_hs_oe", {31'd0, hs_oe}, 32'd0);
    check_val("rst_lp", {30'd0, lp_p, lp_n}, 32'd3);
    check_val("rst_hs_data", {24'd0, hs_data}, 32'h00);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_underflow", {31'd0, underflow}, 32'd0);
    #20 resetb = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) bb[i] = 8'h00;
    bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33;
    run_burst(bb, 3, 3, 4, 3, 2);

    bb[0] = 8'h9A; bb[1] = 8'h01; bb[2] = 8'hC3; bb[3] = 8'h7E; bb[4] = 8'h40;
    run_burst(bb, 5, 5, 3, 2, 3);

    bb[0] = 8'h12; bb[1] = 8'h35; bb[2] = 8'h56; bb[3] = 8'h78;
    run_burst(bb, 4, 2, 2, 1, 2);

    bb[0] = 8'hA5; bb[1] = 8'h5A;
    run_burst(bb, 2, 0, 1, 2, 1);

    bb[0] = 8'hC4; bb[1] = 8'h2B; bb[2] = 8'hF1;
    run_burst(bb, 3, 3, 0, 0, 0);

    // Reset in the middle of the data phase.
    mon_en = 1'b0;
    lp_period = 8'd1; hs_zero = 8'd1; hs_trail = 8'd1;
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
    hit = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      if (hs_oe && in_ready && hs_data == (8'h5A ^ {8{pol}})) hit = 1;
    end
    check_val("reset_reach_data", {31'd0, hit}, 32'd1);
    #2 resetb = 1'b0;
    #1;
    check_val("midrst_hs_oe", {31'd0, hs_oe}, 32'd0);
    check_val("midrst_lp", {30'd0, lp_p, lp_n}, 32'd3);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    #20 resetb = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    bb[0] = 8'h66; bb[1] = 8'h81;
    run_burst(bb, 2, 2, 2, 2, 2);

    check_val("hs_queue_empty", exp_hs.size(), 0);
    check_val("burst_queue_empty", exp_burst.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
